// File: rtl/seq_pkg.sv
// Shared types and default sizes for the serial pattern generator.
package seq_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_REP_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_shifter.sv
// Rotating shift register and bit counter for seq_gen.
// The register rotates rather than shifts, so after WIDTH steps it holds the
// latched pattern again; that copy serves frame repeats and parity.
// Parity output exists only when SEQ_GEN_PARITY_EN is defined.
module seq_shifter
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout_c,
`ifdef SEQ_GEN_PARITY_EN
    output logic             par_c,
`endif
    output logic             last_c
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;

    // Pattern register and bit counter (WIDTH-1 down to 0, then wraps for a repeat)
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= din;
            cnt  <= CNT_W'(WIDTH - 1);
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], sreg[WIDTH-1]};
            cnt  <= (cnt == '0) ? CNT_W'(WIDTH - 1) : cnt - CNT_W'(1);
        end
    end

    // Bit that sits at the MSB after this edge, so the caller can register it
    assign sout_c = load ? din[WIDTH-1] : (shift ? sreg[WIDTH-2] : sreg[WIDTH-1]);
    assign last_c = (cnt == '0);

`ifdef SEQ_GEN_PARITY_EN
    // Even parity; rotation does not change it
    assign par_c = ^sreg;
`endif

endmodule

// File: rtl/seq_gen.sv
// Serial burst generator: sends a latched pattern MSB first, reps+1 times,
// then pulses done. Optional per-frame parity bit with SEQ_GEN_PARITY_EN.
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_nxt;
    logic             out_nxt;
    logic             valid_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             load;
    logic             shift;
    logic             sout_c;
    logic             last_c;
`ifdef SEQ_GEN_PARITY_EN
    logic             par_c;
`endif

    seq_shifter #(.WIDTH(WIDTH)) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .shift  (shift),
        .din    (pattern),
        .sout_c (sout_c),
`ifdef SEQ_GEN_PARITY_EN
        .par_c  (par_c),
`endif
        .last_c (last_c)
    );

    // State, repeat counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rep_q <= '0;
            out   <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            rep_q <= rep_nxt;
            out   <= out_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next state and next-cycle output values
    always_comb begin
        state_nxt = state;
        rep_nxt   = rep_q;
        out_nxt   = 1'b0;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    rep_nxt   = reps;
                    state_nxt = SHIFT;
                    out_nxt   = sout_c;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            SHIFT: begin
                shift    = 1'b1;
                busy_nxt = 1'b1;
                if (!last_c) begin
                    out_nxt   = sout_c;
                    valid_nxt = 1'b1;
                end else begin
`ifdef SEQ_GEN_PARITY_EN
                    state_nxt = PARITY;
                    out_nxt   = par_c;
                    valid_nxt = 1'b1;
`else
                    if (rep_q != '0) begin
                        rep_nxt   = rep_q - REP_W'(1);
                        out_nxt   = sout_c;
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            PARITY: begin
                busy_nxt = 1'b1;
                if (rep_q != '0) begin
                    rep_nxt   = rep_q - REP_W'(1);
                    state_nxt = SHIFT;
                    out_nxt   = sout_c;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_gen.sv
// Testbench for seq_gen: fixed vector table, directed corner sequences and
// randomized traffic against a burst-level reference model.
module tb_seq_gen;

    localparam int W  = 8;
    localparam int RW = 4;
`ifdef SEQ_GEN_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef logic [3:0] obs_t;  // {out, valid, busy, done}

    typedef struct {
        logic          st;
        logic [W-1:0]  pat;
        logic [RW-1:0] rp;
        obs_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  pattern;
    logic [RW-1:0] reps;
    logic          out;
    logic          valid;
    logic          busy;
    logic          done;

    int   checks = 0;
    int   errors = 0;
    obs_t q[$];
    obs_t exp_cur = '0;
    obs_t last_obs;

    always #5 clk = ~clk;

    seq_gen #(.WIDTH(W), .REP_W(RW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .reps    (reps),
        .out     (out),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    // Burst-level model: an accepted start queues every expected output cycle
    function automatic void model_edge(input logic r, input logic s,
                                       input logic [W-1:0] p, input logic [RW-1:0] n);
        int frames;
        if (r) begin
            q.delete();
            exp_cur = '0;
            return;
        end
        if (q.size() == 0 && !exp_cur[1] && s) begin
            frames = int'(n) + 1;
            for (int f = 0; f < frames; f++) begin
                for (int b = W - 1; b >= 0; b--) q.push_back({p[b], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_GEN_PARITY_EN
                q.push_back({^p, 1'b1, 1'b1, 1'b0});
`endif
            end
            q.push_back(4'b0011);
        end
        if (q.size() > 0) exp_cur = q.pop_front();
        else exp_cur = '0;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {out,valid,busy,done}=%b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample and compare at negedge
    task automatic step(input logic r, input logic s,
                        input logic [W-1:0] p, input logic [RW-1:0] n);
        rst = r; start = s; pattern = p; reps = n;
        @(posedge clk);
        model_edge(r, s, p, n);
        @(negedge clk);
        last_obs = {out, valid, busy, done};
        check("model", last_obs, exp_cur);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom), RW'($urandom));
    endtask

    vec_t tbl[11];
    int   n_valid;
    int   n_done;
    int   first_v;
    int   last_v;

    initial begin
        rst = 1'b1; start = 1'b0; pattern = '0; reps = '0;

        // Reset, with start held high to show it is ignored
        step(1'b1, 1'b1, 8'hFF, 4'd3);
        step(1'b1, 1'b1, 8'hFF, 4'd3);
        check("reset", last_obs, 4'b0000);

        // Single frame of 0111_1101; pattern/reps changed after accept
        tbl[0] = '{1'b1, 8'h7D, 4'd0, 4'b0110};
        tbl[1] = '{1'b0, 8'hFF, 4'd5, 4'b1110};
        tbl[2] = '{1'b0, 8'h00, 4'd5, 4'b1110};
        tbl[3] = '{1'b0, 8'hFF, 4'd5, 4'b1110};
        tbl[4] = '{1'b0, 8'h00, 4'd5, 4'b1110};
        tbl[5] = '{1'b0, 8'hFF, 4'd5, 4'b1110};
        tbl[6] = '{1'b0, 8'h00, 4'd5, 4'b0110};
        tbl[7] = '{1'b0, 8'hFF, 4'd5, 4'b1110};
`ifdef SEQ_GEN_PARITY_EN
        tbl[8] = '{1'b0, 8'h00, 4'd0, 4'b0110};
        tbl[9] = '{1'b0, 8'h00, 4'd0, 4'b0011};
`else
        tbl[8] = '{1'b0, 8'h00, 4'd0, 4'b0011};
        tbl[9] = '{1'b0, 8'h00, 4'd0, 4'b0000};
`endif
        tbl[10] = '{1'b0, 8'h00, 4'd0, 4'b0000};
        for (int i = 0; i < 11; i++) begin
            step(1'b0, tbl[i].st, tbl[i].pat, tbl[i].rp);
            check($sformatf("table[%0d]", i), last_obs, tbl[i].exp);
        end

        // reps=2, 8'hA5: one continuous valid run of 3 frames, one done pulse
        idle(2);
        n_valid = 0; n_done = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 41; i++) begin
            if (i == 0) step(1'b0, 1'b1, 8'hA5, 4'd2);
            else step(1'b0, 1'b0, W'($urandom), RW'($urandom));
            if (last_obs[2]) begin
                n_valid++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
            n_done += int'(last_obs[0]);
        end
        check_int("reps2_valid_count", n_valid, 3 * FL);
        check_int("reps2_valid_run", last_v - first_v + 1, 3 * FL);
        check_int("reps2_done_pulses", n_done, 1);

`ifdef SEQ_GEN_PARITY_EN
        // Parity bit for 8'h07 (odd count) and 8'h03 (even count)
        step(1'b0, 1'b1, 8'h07, 4'd0);
        idle(8);
        check("parity_07", last_obs, 4'b1110);
        idle(3);
        step(1'b0, 1'b1, 8'h03, 4'd0);
        idle(8);
        check("parity_03", last_obs, 4'b0110);
        idle(3);
`endif

        // start re-asserted mid-burst is ignored; start after done is accepted
        step(1'b0, 1'b1, 8'hC6, 4'd0);
        n_done = 0;
        step(1'b0, 1'b0, 8'hC6, 4'd0);
        step(1'b0, 1'b0, 8'hC6, 4'd0);
        step(1'b0, 1'b1, 8'h3F, 4'd7);
        for (int i = 0; i < 40 && !last_obs[0]; i++) begin
            step(1'b0, 1'b0, 8'h3F, 4'd7);
            n_done += int'(last_obs[0]);
        end
        check_int("restart_done_pulses", n_done, 1);
        step(1'b0, 1'b1, 8'h81, 4'd0);
        check("start_in_done_ignored", last_obs, 4'b0000);
        step(1'b0, 1'b1, 8'h81, 4'd0);
        check("start_after_done", last_obs, 4'b1110);
        idle(12);

        // Reset at bit 4 of a reps=3 burst
        step(1'b0, 1'b1, 8'h5A, 4'd3);
        idle(3);
        step(1'b1, 1'b1, 8'hFF, 4'd3);
        check("mid_reset", last_obs, 4'b0000);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 8'h00, 4'd0);
            n_done += int'(last_obs[0]);
        end
        check_int("mid_reset_no_done", n_done, 0);
        step(1'b0, 1'b1, 8'h81, 4'd0);
        check("post_reset_msb", last_obs, 4'b1110);
        idle(12);

        // Maximum reps: 2^REP_W frames, no counter wrap
        n_valid = 0; n_done = 0;
        step(1'b0, 1'b1, 8'h96, 4'd15);
        n_valid += int'(last_obs[2]);
        for (int i = 0; i < 16 * FL + 8; i++) begin
            idle(1);
            n_valid += int'(last_obs[2]);
            n_done  += int'(last_obs[0]);
        end
        check_int("max_reps_valid", n_valid, 16 * FL);
        check_int("max_reps_done", n_done, 1);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 W'($urandom), RW'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
